uart_date_sender: RTL and testbench
===================================

UART_DATE_SENDER -- requirements
Module: uart_date_sender

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 8: width of the character bus to the transmitter.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 16: maximum cycles to wait for transmitter busy to rise after an enable pulse.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port send_req  input  1  request to transmit one timestamp line; sampled only in IDLE.
REQ-006 SHALL have port year_bcd  input  16  four BCD digits, most significant nibble first.
REQ-007 SHALL have ports month_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd  input  8 each  two BCD digits each.
REQ-008 SHALL have port uart_tx_busy  input  1  transmitter busy flag.
REQ-009 SHALL have port uart_tx_en  output  1  one-cycle character-load strobe to the transmitter.
REQ-010 SHALL have port uart_tx_data  output  PAYLOAD_BITS  ASCII character to transmit, registered.
REQ-011 SHALL have port send_busy  output  1  high from request acceptance until return to IDLE.
REQ-012 SHALL have port send_done  output  1  one-cycle pulse after the last character completes.
REQ-013 SHALL have port send_err  output  1  one-cycle pulse on a busy-timeout abort.

Function
REQ-014 SHALL emit exactly 21 characters, index 0..20: Y3 Y2 Y1 Y0 '-' M1 M0 '-' D1 D0 ' ' h1 h0 ':' m1 m0 ':' s1 s0 CR(0x0D) LF(0x0A).
REQ-015 SHALL encode each digit nibble n<=9 as 0x30+n and each nibble >=0xA as '?' (0x3F); separators are '-'=0x2D, ' '=0x20, ':'=0x3A.
REQ-016 SHALL snapshot all six BCD inputs on the cycle send_req is accepted; later input changes SHALL NOT affect the line in progress.
REQ-017 SHALL implement the FSM states IDLE, LOAD, WAIT_BUSY, and WAIT_DONE.
REQ-018 SHALL, in IDLE with send_req=1, snapshot the inputs, set index=0, set send_busy=1, and go to LOAD on the next cycle.
REQ-019 SHALL, in LOAD, drive uart_tx_data=char[index] and uart_tx_en=1 for exactly one cycle, clear the timeout counter, and go to WAIT_BUSY.
REQ-020 SHALL, in WAIT_BUSY, go to WAIT_DONE when uart_tx_busy=1 and otherwise increment the timeout counter.
REQ-021 SHALL, when the timeout counter reaches BUSY_TIMEOUT in WAIT_BUSY, pulse send_err, clear send_busy, and return to IDLE.
REQ-022 SHALL, in WAIT_DONE with uart_tx_busy=0, go to LOAD with index+1 if index<20.
REQ-023 SHALL, in WAIT_DONE with uart_tx_busy=0 and index=20, pulse send_done, clear send_busy, and return to IDLE.
REQ-024 SHALL hold uart_tx_data stable from LOAD until the next LOAD; uart_tx_en SHALL never be high in two consecutive cycles.
REQ-025 SHALL ignore send_req outside IDLE, with no queuing.
REQ-026 SHALL accept a new request in IDLE on the cycle after send_done, which gives back-to-back lines.
REQ-027 SHALL keep the index counter 5 bits wide and never exceed 20.
REQ-028 SHALL never assert send_done and send_err in the same cycle.

Reset
REQ-029 SHALL, on reset=1 at any time including mid-line, go immediately to IDLE with uart_tx_en=0, uart_tx_data=0x00, send_busy=0, send_done=0, send_err=0, index=0, and timeout=0.
REQ-030 SHALL, after reset deassertion, stay in IDLE until send_req=1 is sampled.

Verification
REQ-031 SHALL cover: year 0x2024, month 0x07, day 0x09, time 0x13/0x05/0x59 with a transmitter model (busy rises 1 cycle after en, holds 11 cycles) -> captured bytes "2024-07-09 13:05:59\r\n", 21 strobes, then one send_done pulse.
REQ-032 SHALL cover: hour_bcd=0x1A -> character 12 = 0x3F; all other characters are unaffected.
REQ-033 SHALL cover: changing sec_bcd and pulsing send_req during character 5 -> the line still carries the snapshot values, and the second request produces no second line.
REQ-034 SHALL cover: uart_tx_busy tied 0 -> one en pulse, send_err pulse exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY, then send_busy=0 and no further strobes.
REQ-035 SHALL cover: reset asserted during character 10 -> outputs reach their reset values asynchronously; a new request afterwards restarts at character 0 ('2').
REQ-036 SHALL cover: send_req held high continuously -> two consecutive complete lines, with en never high on adjacent cycles.

Source files
------------

// File: rtl/uart_date_sender.sv
// Serialises a BCD timestamp as "YYYY-MM-DD hh:mm:ss\r\n" into a byte-wide UART transmitter,
// one character per load strobe, with a busy-handshake timeout.
module uart_date_sender #(
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    send_req,
    input  logic [15:0]             year_bcd,
    input  logic [7:0]              month_bcd,
    input  logic [7:0]              day_bcd,
    input  logic [7:0]              hour_bcd,
    input  logic [7:0]              min_bcd,
    input  logic [7:0]              sec_bcd,
    input  logic                    uart_tx_busy,
    output logic                    uart_tx_en,
    output logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    send_busy,
    output logic                    send_done,
    output logic                    send_err
);

    localparam int unsigned TmoW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(BUSY_TIMEOUT - 1);
    localparam logic [4:0] LastIdx = 5'd20;

    typedef enum logic [1:0] {StIdle, StLoad, StWaitBusy, StWaitDone} state_e;

    state_e                  state_q, state_d;
    logic [4:0]              idx_q, idx_d;
    logic [TmoW-1:0]         tmo_q, tmo_d;
    logic [55:0]             snap_q, snap_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    en_q, en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    function automatic logic [7:0] digit(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 | {4'h0, n}) : 8'h3F;
    endfunction

    // snap layout: year[55:40] month[39:32] day[31:24] hour[23:16] min[15:8] sec[7:0]
    function automatic logic [7:0] char_of(input logic [4:0] idx, input logic [55:0] s);
        logic [7:0] c;
        c = 8'h00;
        case (idx)
            5'd0:    c = digit(s[55:52]);
            5'd1:    c = digit(s[51:48]);
            5'd2:    c = digit(s[47:44]);
            5'd3:    c = digit(s[43:40]);
            5'd4:    c = 8'h2D;
            5'd5:    c = digit(s[39:36]);
            5'd6:    c = digit(s[35:32]);
            5'd7:    c = 8'h2D;
            5'd8:    c = digit(s[31:28]);
            5'd9:    c = digit(s[27:24]);
            5'd10:   c = 8'h20;
            5'd11:   c = digit(s[23:20]);
            5'd12:   c = digit(s[19:16]);
            5'd13:   c = 8'h3A;
            5'd14:   c = digit(s[15:12]);
            5'd15:   c = digit(s[11:8]);
            5'd16:   c = 8'h3A;
            5'd17:   c = digit(s[7:4]);
            5'd18:   c = digit(s[3:0]);
            5'd19:   c = 8'h0D;
            5'd20:   c = 8'h0A;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        snap_d  = snap_q;
        data_d  = data_q;
        en_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (send_req) begin
                    snap_d  = {year_bcd, month_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd};
                    idx_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                tmo_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (uart_tx_busy) begin
                    state_d = StWaitDone;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    tmo_d   = '0;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!uart_tx_busy) begin
                    if (idx_q == LastIdx) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Strobe and character are registered on entry so both are valid throughout LOAD.
        if (state_d == StLoad) begin
            en_d   = 1'b1;
            data_d = PAYLOAD_BITS'(char_of(idx_d, snap_d));
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tmo_q   <= '0;
            snap_q  <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign uart_tx_en   = en_q;
    assign uart_tx_data = data_q;
    assign send_busy    = busy_q;
    assign send_done    = done_q;
    assign send_err     = err_q;

endmodule

// File: tb/tb_uart_date_sender.sv
// Scoreboard bench for uart_date_sender: stimulus pushes expected characters/events,
// a negedge monitor pops and compares them as the DUT strobes, finishes or aborts.
module tb_uart_date_sender;

    localparam int unsigned PB = 8;
    localparam int unsigned BT = 16;
    localparam int EvDone = 256;
    localparam int EvErr  = 257;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          send_req = 1'b0;
    logic [15:0]   year_bcd;
    logic [7:0]    month_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd;
    logic          uart_tx_busy;
    logic          uart_tx_en;
    logic [PB-1:0] uart_tx_data;
    logic          send_busy, send_done, send_err;

    int passed = 0;
    int total = 0;
    int exp_q[$];
    int tx_cnt = 0;
    bit tx_on = 1'b1;
    int cyc = 0;
    int strobe_cnt = 0;
    int en_cyc = 0;
    int err_lat = -1;
    logic prev_en = 1'b0;

    uart_date_sender #(
        .PAYLOAD_BITS(PB),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .send_req(send_req),
        .year_bcd(year_bcd),
        .month_bcd(month_bcd),
        .day_bcd(day_bcd),
        .hour_bcd(hour_bcd),
        .min_bcd(min_bcd),
        .sec_bcd(sec_bcd),
        .uart_tx_busy(uart_tx_busy),
        .uart_tx_en(uart_tx_en),
        .uart_tx_data(uart_tx_data),
        .send_busy(send_busy),
        .send_done(send_done),
        .send_err(send_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Transmitter model: busy rises one cycle after the strobe and stays high 11 cycles.
    assign uart_tx_busy = tx_on && (tx_cnt >= 1) && (tx_cnt <= 11);
    always @(negedge CLK) begin
        if (reset) tx_cnt <= 0;
        else if (uart_tx_en) tx_cnt <= 12;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end

    always @(negedge CLK) begin
        if (uart_tx_en) begin
            check("en_gap", int'(prev_en), 0);
            strobe_cnt++;
            en_cyc = cyc;
            if (exp_q.size() == 0) check("strobe_expected", 1, 0);
            else check("char", int'(uart_tx_data), exp_q.pop_front());
        end
        if (send_done || send_err) check("done_err_excl", int'(send_done & send_err), 0);
        if (send_done) begin
            if (exp_q.size() == 0) check("done_expected", 1, 0);
            else check("done_event", EvDone, exp_q.pop_front());
        end
        if (send_err) begin
            err_lat = cyc - en_cyc;
            if (exp_q.size() == 0) check("err_expected", 1, 0);
            else check("err_event", EvErr, exp_q.pop_front());
        end
        prev_en = uart_tx_en;
    end

    task automatic push_line(input string s);
        for (int i = 0; i < 19; i++) exp_q.push_back(int'(s[i]));
        exp_q.push_back(32'h0D);
        exp_q.push_back(32'h0A);
        exp_q.push_back(EvDone);
    endtask

    task automatic set_inputs(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                              input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        year_bcd  = y;
        month_bcd = mo;
        day_bcd   = d;
        hour_bcd  = h;
        min_bcd   = mi;
        sec_bcd   = s;
    endtask

    task automatic pulse_req();
        @(negedge CLK);
        send_req = 1'b1;
        @(negedge CLK);
        send_req = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLK);
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (30) @(negedge CLK);
    endtask

    task automatic wait_strobes(input int n, input string name);
        for (int i = 0; i < 2000; i++) begin
            if (strobe_cnt >= n) break;
            @(negedge CLK);
        end
        check(name, int'(strobe_cnt >= n), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, int'(uart_tx_en), 0);
        check({tag, "_data"}, int'(uart_tx_data), 0);
        check({tag, "_busy"}, int'(send_busy), 0);
        check({tag, "_done"}, int'(send_done), 0);
        check({tag, "_err"}, int'(send_err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        set_inputs(16'h2024, 8'h07, 8'h09, 8'h13, 8'h05, 8'h59);
        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        reset = 1'b0;
        repeat (5) @(negedge CLK);
        check("idle_busy", int'(send_busy), 0);

        // Nominal line
        base = strobe_cnt;
        push_line("2024-07-09 13:05:59");
        pulse_req();
        check("busy_after_accept", int'(send_busy), 1);
        drain("t1_drain");
        check("t1_strobes", strobe_cnt - base, 21);
        check("t1_busy_clear", int'(send_busy), 0);

        // Non-decimal nibble becomes '?'
        hour_bcd = 8'h1A;
        base = strobe_cnt;
        push_line("2024-07-09 1?:05:59");
        pulse_req();
        drain("t2_drain");
        check("t2_strobes", strobe_cnt - base, 21);
        hour_bcd = 8'h13;

        // Snapshot holds; mid-line request is dropped
        base = strobe_cnt;
        push_line("2024-07-09 13:05:59");
        pulse_req();
        wait_strobes(base + 6, "t3_reach_char5");
        sec_bcd = 8'h00;
        send_req = 1'b1;
        @(negedge CLK);
        send_req = 1'b0;
        drain("t3_drain");
        check("t3_strobes", strobe_cnt - base, 21);
        sec_bcd = 8'h59;

        // Busy never rises: timeout abort
        tx_on = 1'b0;
        base = strobe_cnt;
        exp_q.push_back(int'(8'h32));
        exp_q.push_back(EvErr);
        pulse_req();
        drain("t4_drain");
        check("t4_err_latency", err_lat, BT + 1);
        check("t4_busy_clear", int'(send_busy), 0);
        check("t4_strobes", strobe_cnt - base, 1);
        tx_on = 1'b1;

        // Asynchronous reset mid-line, then restart from character 0
        push_line("2024-07-09 13:05:59");
        base = strobe_cnt;
        pulse_req();
        wait_strobes(base + 11, "t5_reach_char10");
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        base = strobe_cnt;
        push_line("2024-07-09 13:05:59");
        pulse_req();
        drain("t5_drain");
        check("t5_strobes", strobe_cnt - base, 21);

        // Request held high: back-to-back lines
        base = strobe_cnt;
        push_line("2024-07-09 13:05:59");
        push_line("2024-07-09 13:05:59");
        @(negedge CLK);
        send_req = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (send_done) break;
        end
        check("t6_first_done", int'(send_done), 1);
        @(negedge CLK);
        send_req = 1'b0;
        check("t6_rearm_busy", int'(send_busy), 1);
        drain("t6_drain");
        check("t6_strobes", strobe_cnt - base, 42);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
